mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates one shared memory port between an instruction-fetch requester
// and a load/store requester.  Only one memory transaction is ever in flight.
// Data requests normally win, but after STARVE_LIMIT consecutive data grants
// with fetch waiting, fetch is given the next grant.
//
// Handshake: a requester holds *_req until it sees *_gnt (a one-cycle pulse
// in IDLE).  The arbiter then holds mem_req with stable fields until mem_gnt,
// and forwards the single-cycle mem_rvalid/mem_rdata response to the owner.
//
// Ports
//   clock, reset          : clock, synchronous active-low reset
//   if_req/if_addr        : fetch request (read only)
//   if_gnt/if_rvalid/if_rdata : fetch accept pulse and response
//   d_req/d_we/d_be/d_addr/d_wdata : load/store request
//   d_gnt/d_rvalid/d_rdata : data accept pulse and response
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata : shared memory request
//   mem_gnt/mem_rvalid/mem_rdata : memory accept and response
//   busy                  : a transaction is in progress
//   protocol_err          : sticky, set by a response with nothing waiting
//   dbg_state             : current FSM state (0 IDLE, 1 REQ, 2 WAIT)
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN/8-1:0] d_be,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              busy,
    output logic              protocol_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_starve;
    logic                r_err;
    logic                r_live;     // low during reset and the cycle after
    logic                r_own_f;
    logic                r_own_d;
    logic                r_we;
    logic [XLEN/8-1:0]   r_be;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_wdata;

    logic                w_live;
    logic                w_pick_f;
    logic                w_pick_d;
    logic                w_accept;

    // Outputs are held quiet while reset is low and for one cycle after it.
    assign w_live   = reset & r_live;
    assign w_pick_f = if_req & (~d_req | (r_starve == LIMIT));
    assign w_pick_d = d_req & ~w_pick_f;
    assign w_accept = w_live & (r_state == S_IDLE) & (if_req | d_req);

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_next_state = S_REQ;
            S_REQ:   if (mem_gnt)    w_next_state = S_WAIT;
            S_WAIT:  if (mem_rvalid) w_next_state = S_IDLE;
            default:                 w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_req   = 1'b0;
        busy      = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if (w_live) begin
            case (r_state)
                S_IDLE: begin
                    if_gnt = w_pick_f;
                    d_gnt  = w_pick_d;
                end
                S_REQ: begin
                    mem_req = 1'b1;
                    busy    = 1'b1;
                end
                S_WAIT: begin
                    busy      = 1'b1;
                    if_rvalid = r_own_f & mem_rvalid;
                    d_rvalid  = r_own_d & mem_rvalid;
                end
                default: ;
            endcase
        end
    end

    assign if_rdata     = if_rvalid ? mem_rdata : '0;
    assign d_rdata      = d_rvalid  ? mem_rdata : '0;
    assign mem_we       = mem_req & r_we;
    assign mem_be       = mem_req ? r_be    : '0;
    assign mem_addr     = mem_req ? r_addr  : '0;
    assign mem_wdata    = mem_req ? r_wdata : '0;
    assign protocol_err = r_err;
    assign dbg_state    = r_state;

    // Request capture, owner and starvation tracking
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_live   <= 1'b0;
            r_starve <= '0;
            r_own_f  <= 1'b0;
            r_own_d  <= 1'b0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_own_f <= w_pick_f;
                r_own_d <= w_pick_d;
                if (w_pick_f) begin
                    r_we    <= 1'b0;
                    r_be    <= '1;
                    r_addr  <= if_addr;
                    r_wdata <= '0;
                end else begin
                    r_we    <= d_we;
                    r_be    <= d_be;
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                end
            end
            // Count data grants that made fetch wait; any idle cycle without
            // a fetch request, or a fetch grant, starts the count over.
            if (w_live && (r_state == S_IDLE)) begin
                if (!if_req || w_pick_f) begin
                    r_starve <= '0;
                end else if (w_pick_d && (r_starve < LIMIT)) begin
                    r_starve <= r_starve + 4'd1;
                end
            end
        end
    end

    // A response with no transaction waiting for it is a protocol error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (mem_rvalid && (r_state != S_WAIT)) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy, protocol_err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .protocol_err(protocol_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // let combinational outputs settle after input changes
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // expected grant order under contention: 1 = fetch, 0 = data
    logic [9:0] exp_order;

    initial begin
        exp_order  = 10'b1000010000; // bit i = grant i
        reset      = 1'b0;
        if_req     = 1'b1;   // held during reset: must not be granted
        if_addr    = 32'h0;
        d_req      = 1'b0; d_we = 1'b0; d_be = 4'h0;
        d_addr     = 32'h0; d_wdata = 32'h0;
        mem_gnt    = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // ---- reset ----
        cyc(); cyc();
        settle();
        chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_err", {31'b0, protocol_err}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;
        settle();
        chk("post_rst_if_gnt", {31'b0, if_gnt}, 32'd0);
        if_req = 1'b0;
        cyc();

        // ---- fetch read ----
        if_req = 1'b1; if_addr = 32'h100;
        settle();
        chk("f_if_gnt", {31'b0, if_gnt}, 32'd1);
        chk("f_d_gnt", {31'b0, d_gnt}, 32'd0);
        chk("f_mem_req0", {31'b0, mem_req}, 32'd0);
        cyc();
        if_req = 1'b0; if_addr = 32'h0; mem_gnt = 1'b1;
        settle();
        chk("f_mem_req1", {31'b0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", {31'b0, mem_we}, 32'd0);
        chk("f_mem_be", {28'b0, mem_be}, 32'hF);
        chk("f_mem_wdata", mem_wdata, 32'h0);
        chk("f_busy", {31'b0, busy}, 32'd1);
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
        settle();
        chk("f_if_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("f_if_rdata", if_rdata, 32'h13);
        chk("f_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("f_mem_req2", {31'b0, mem_req}, 32'd0);
        cyc();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        settle();
        chk("f_idle_busy", {31'b0, busy}, 32'd0);
        chk("f_idle_rdata", if_rdata, 32'h0);

        // ---- store with mem_gnt delayed 3 cycles ----
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h204;
        d_wdata = 32'hBEEF;
        settle();
        chk("s_d_gnt", {31'b0, d_gnt}, 32'd1);
        chk("s_if_gnt", {31'b0, if_gnt}, 32'd0);
        cyc();
        // requester moves on; captured fields must not follow
        d_req = 1'b0; d_we = 1'b0; d_be = 4'hF; d_addr = 32'hFFF;
        d_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3);
            settle();
            chk("s_mem_req", {31'b0, mem_req}, 32'd1);
            chk("s_mem_addr", mem_addr, 32'h204);
            chk("s_mem_wdata", mem_wdata, 32'hBEEF);
            chk("s_mem_be", {28'b0, mem_be}, 32'h3);
            chk("s_mem_we", {31'b0, mem_we}, 32'd1);
            cyc();
        end
        // stray mem_gnt in WAIT is ignored
        mem_gnt = 1'b1;
        settle();
        chk("s_wait_mem_req", {31'b0, mem_req}, 32'd0);
        chk("s_wait_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        cyc();
        mem_gnt = 1'b0;
        settle();
        chk("s_wait_state", {30'b0, dbg_state}, 32'd2);
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        settle();
        chk("s_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        chk("s_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        cyc();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        settle();
        chk("s_done_busy", {31'b0, busy}, 32'd0);
        chk("s_done_d_rvalid", {31'b0, d_rvalid}, 32'd0);

        // ---- contention: both held continuously ----
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h300;
        for (int g = 0; g < 10; g++) begin
            settle();
            chk("c_if_gnt", {31'b0, if_gnt}, {31'b0, exp_order[g]});
            chk("c_d_gnt", {31'b0, d_gnt}, {31'b0, ~exp_order[g]});
            cyc();
            mem_gnt = 1'b1;
            settle();
            chk("c_no_gnt_in_req", {30'b0, if_gnt, d_gnt}, 32'd0);
            chk("c_mem_addr", mem_addr, exp_order[g] ? 32'h400 : 32'h300);
            cyc();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0 + g;
            settle();
            chk("c_rvalid", {30'b0, if_rvalid, d_rvalid},
                exp_order[g] ? 32'd2 : 32'd1);
            cyc();
            mem_rvalid = 1'b0; mem_rdata = 32'h0;
        end
        if_req = 1'b0; d_req = 1'b0;
        cyc();

        // ---- stray response in IDLE ----
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        settle();
        chk("x_if_rvalid", {31'b0, if_rvalid}, 32'd0);
        chk("x_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("x_if_rdata", if_rdata, 32'h0);
        chk("x_err_before", {31'b0, protocol_err}, 32'd0);
        cyc();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        settle();
        chk("x_err_set", {31'b0, protocol_err}, 32'd1);
        cyc(); cyc();
        chk("x_err_sticky", {31'b0, protocol_err}, 32'd1);

        // ---- reset during WAIT ----
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h500;
        settle();
        chk("r_d_gnt", {31'b0, d_gnt}, 32'd1);
        cyc();
        d_req = 1'b0; mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        settle();
        chk("r_wait_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        settle();
        chk("r_in_rst_busy", {31'b0, busy}, 32'd0);
        cyc();
        reset = 1'b1;
        settle();
        chk("r_after_busy", {31'b0, busy}, 32'd0);
        chk("r_after_state", {30'b0, dbg_state}, 32'd0);
        chk("r_after_err", {31'b0, protocol_err}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h99;   // late response
        settle();
        chk("r_late_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        chk("r_late_d_rdata", d_rdata, 32'h0);
        cyc();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        if_req = 1'b1; if_addr = 32'h600;
        settle();
        chk("r_new_if_gnt", {31'b0, if_gnt}, 32'd1);
        cyc();
        if_req = 1'b0; mem_gnt = 1'b1;
        settle();
        chk("r_new_mem_addr", mem_addr, 32'h600);
        cyc();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        settle();
        chk("r_new_if_rvalid", {31'b0, if_rvalid}, 32'd1);
        chk("r_new_if_rdata", if_rdata, 32'h77);
        cyc();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        settle();
        chk("r_new_done_busy", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
